id_ex_stage: RTL and testbench

ID/EX pipeline register with load-use hazard detection and control-hazard flush. Captures the decoded control bundle from the opcode controller, plus register operands, immediate and PC, and presents them to the execute stage one cycle later. It raises a single-cycle stall toward the PC and IF/ID register on a load-use dependency and inserts bubbles on stall or on a taken jump/branch redirect. A saturating counter records every inserted bubble for performance debug.

---
 rtl/id_ex_stage_if.sv | 76 +++++++
 rtl/id_ex_stage.sv | 118 +++++++++++
 tb/tb_id_ex_stage.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the decode-side inputs and execute-side outputs of the ID/EX
// pipeline register.
//   master : the surrounding pipeline. It drives the id_* fields and
//            ex_branch_taken. It observes stall_out, the ex_* fields and
//            bubble_count.
//   slave  : id_ex_stage. It consumes the id_* fields and ex_branch_taken.
//            It produces stall_out, the ex_* fields and bubble_count.
// Handshake: there is no valid/ready pair. id_valid qualifies the ID slot
// and ex_valid qualifies the EX slot. While stall_out is high, the producer
// must hold the ID instruction so that it is presented again next cycle.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // decode side
  logic                      id_valid;
  logic [2:0]                id_jump_type;
  logic                      id_mem_write;
  logic                      id_mem_read;
  logic                      id_mem_to_reg;
  logic                      id_reg_write;
  logic                      id_alu_second_input_is_immidiate;
  logic [3:0]                id_alu_select;
  logic [REG_ADDR_WIDTH-1:0] id_rs;
  logic [REG_ADDR_WIDTH-1:0] id_rt;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic [DATA_WIDTH-1:0]     id_rs_data;
  logic [DATA_WIDTH-1:0]     id_rt_data;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [DATA_WIDTH-1:0]     id_pc;
  logic                      ex_branch_taken;

  // execute side
  logic                      stall_out;
  logic                      ex_valid;
  logic [2:0]                ex_jump_type;
  logic [3:0]                ex_alu_select;
  logic                      ex_mem_write;
  logic                      ex_mem_read;
  logic                      ex_mem_to_reg;
  logic                      ex_reg_write;
  logic                      ex_alu_second_input_is_immidiate;
  logic [REG_ADDR_WIDTH-1:0] ex_rs;
  logic [REG_ADDR_WIDTH-1:0] ex_rt;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic [DATA_WIDTH-1:0]     ex_rs_data;
  logic [DATA_WIDTH-1:0]     ex_rt_data;
  logic [DATA_WIDTH-1:0]     ex_imm;
  logic [DATA_WIDTH-1:0]     ex_pc;
  logic [15:0]               bubble_count;

  modport master (
    output id_valid, id_jump_type, id_mem_write, id_mem_read, id_mem_to_reg,
           id_reg_write, id_alu_second_input_is_immidiate, id_alu_select,
           id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_pc,
           ex_branch_taken,
    input  stall_out, ex_valid, ex_jump_type, ex_alu_select, ex_mem_write,
           ex_mem_read, ex_mem_to_reg, ex_reg_write,
           ex_alu_second_input_is_immidiate, ex_rs, ex_rt, ex_rd,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc, bubble_count
  );

  modport slave (
    input  id_valid, id_jump_type, id_mem_write, id_mem_read, id_mem_to_reg,
           id_reg_write, id_alu_second_input_is_immidiate, id_alu_select,
           id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm, id_pc,
           ex_branch_taken,
    output stall_out, ex_valid, ex_jump_type, ex_alu_select, ex_mem_write,
           ex_mem_read, ex_mem_to_reg, ex_reg_write,
           ex_alu_second_input_is_immidiate, ex_rs, ex_rt, ex_rd,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection and flush.
//   clk      : single clock; all state updates on the rising edge
//   reset_n  : asynchronous, active-low reset
//   bus      : id_ex_stage_if.slave
//     id_*            decoded instruction presented by the ID stage
//     ex_branch_taken the EX stage resolved a redirect this cycle
//     stall_out       combinational; hold the PC and IF/ID this cycle
//     ex_*            registered instruction presented to the EX stage
//     bubble_count    saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic           clk,
  input  logic           reset_n,
  id_ex_stage_if.slave   bus
);

  typedef struct packed {
    logic                      valid;
    logic [2:0]                jump_type;
    logic [3:0]                alu_select;
    logic                      mem_write;
    logic                      mem_read;
    logic                      mem_to_reg;
    logic                      reg_write;
    logic                      alu_imm;
    logic [REG_ADDR_WIDTH-1:0] rs;
    logic [REG_ADDR_WIDTH-1:0] rt;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [DATA_WIDTH-1:0]     imm;
    logic [DATA_WIDTH-1:0]     pc;
  } ex_bundle_t;

  ex_bundle_t  ex_d, ex_q;
  logic [15:0] bubble_count_d, bubble_count_q;

  logic rt_used;
  logic load_use;
  logic insert_bubble;
  logic stall;

  always_comb begin
    // Immediate-form ALU ops ignore rt unless they are stores, which still
    // need rt as the store data.
    rt_used  = !bus.id_alu_second_input_is_immidiate | bus.id_mem_write;

    // Register 0 is hard-wired, so a load targeting it is never a hazard.
    load_use = bus.id_valid & ex_q.valid & ex_q.mem_read & ex_q.reg_write &
               (ex_q.rd != '0) &
               ((bus.id_rs == ex_q.rd) | (rt_used & (bus.id_rt == ex_q.rd)));

    // A redirect squashes the ID instruction anyway, so it suppresses the stall.
    stall         = load_use & !bus.ex_branch_taken;
    insert_bubble = bus.ex_branch_taken | load_use;

    ex_d.valid      = bus.id_valid;
    ex_d.jump_type  = bus.id_jump_type;
    ex_d.alu_select = bus.id_alu_select;
    ex_d.mem_write  = bus.id_mem_write;
    ex_d.mem_read   = bus.id_mem_read;
    ex_d.mem_to_reg = bus.id_mem_to_reg;
    ex_d.reg_write  = bus.id_reg_write;
    ex_d.alu_imm    = bus.id_alu_second_input_is_immidiate;
    ex_d.rs         = bus.id_rs;
    ex_d.rt         = bus.id_rt;
    ex_d.rd         = bus.id_rd;
    ex_d.rs_data    = bus.id_rs_data;
    ex_d.rt_data    = bus.id_rt_data;
    ex_d.imm        = bus.id_imm;
    ex_d.pc         = bus.id_pc;

    // An all-zero bundle is a harmless bubble: jump_type 000 is "no jump",
    // and all write enables are clear. Clearing mem_read also makes a stall
    // last exactly one cycle.
    bubble_count_d = bubble_count_q;
    if (insert_bubble) begin
      ex_d = '0;
      if (bubble_count_q != 16'hFFFF) begin
        bubble_count_d = bubble_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q           <= '0;
      bubble_count_q <= '0;
    end else begin
      ex_q           <= ex_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign bus.stall_out                        = stall;
  assign bus.ex_valid                         = ex_q.valid;
  assign bus.ex_jump_type                     = ex_q.jump_type;
  assign bus.ex_alu_select                    = ex_q.alu_select;
  assign bus.ex_mem_write                     = ex_q.mem_write;
  assign bus.ex_mem_read                      = ex_q.mem_read;
  assign bus.ex_mem_to_reg                    = ex_q.mem_to_reg;
  assign bus.ex_reg_write                     = ex_q.reg_write;
  assign bus.ex_alu_second_input_is_immidiate = ex_q.alu_imm;
  assign bus.ex_rs                            = ex_q.rs;
  assign bus.ex_rt                            = ex_q.rt;
  assign bus.ex_rd                            = ex_q.rd;
  assign bus.ex_rs_data                       = ex_q.rs_data;
  assign bus.ex_rt_data                       = ex_q.rt_data;
  assign bus.ex_imm                           = ex_q.imm;
  assign bus.ex_pc                            = ex_q.pc;
  assign bus.bubble_count                     = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage. Inputs change on the falling edge.
// Combinational stall_out is read 1 ns after the inputs change.
// Registered outputs are read 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic clk;
  logic reset_n;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_bubbles = 0;

  id_ex_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_id();
    bus.id_valid = 1'b0;
    bus.id_jump_type = 3'd0;
    bus.id_mem_write = 1'b0;
    bus.id_mem_read = 1'b0;
    bus.id_mem_to_reg = 1'b0;
    bus.id_reg_write = 1'b0;
    bus.id_alu_second_input_is_immidiate = 1'b0;
    bus.id_alu_select = 4'd0;
    bus.id_rs = 5'd0;
    bus.id_rt = 5'd0;
    bus.id_rd = 5'd0;
    bus.id_rs_data = 32'd0;
    bus.id_rt_data = 32'd0;
    bus.id_imm = 32'd0;
    bus.id_pc = 32'd0;
    bus.ex_branch_taken = 1'b0;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    clear_id();
    bus.id_valid = 1'b1;
    bus.id_mem_read = 1'b1;
    bus.id_mem_to_reg = 1'b1;
    bus.id_reg_write = 1'b1;
    bus.id_alu_second_input_is_immidiate = 1'b1;
    bus.id_rs = 5'd1;
    bus.id_rd = rd;
    bus.id_imm = 32'd8;
  endtask

  task automatic to_negedge();
    @(negedge clk);
  endtask

  task automatic after_posedge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    to_negedge();
    reset_n = 1'b0;
    bus.id_valid = 1'b1;
    bus.id_jump_type = 3'($urandom_range(0, 7));
    bus.id_mem_read = 1'b1;
    bus.id_reg_write = 1'b1;
    bus.id_alu_select = 4'($urandom_range(1, 15));
    bus.id_rs = 5'($urandom_range(1, 31));
    bus.id_rd = 5'($urandom_range(1, 31));
    bus.id_rs_data = $urandom;
    bus.id_pc = $urandom;
    after_posedge();
    after_posedge();
    total_cnt++;
    if (bus.ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %0b want 0", bus.ex_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.ex_alu_select !== 4'd0 || bus.ex_rd !== 5'd0 || bus.ex_rs_data !== 32'd0 ||
        bus.ex_pc !== 32'd0 || bus.ex_jump_type !== 3'd0 || bus.ex_mem_read !== 1'b0)
      $display("FAIL reset_ex_fields alu=%0h rd=%0d rs_data=%0h pc=%0h jt=%0d mr=%0b want all 0",
               bus.ex_alu_select, bus.ex_rd, bus.ex_rs_data, bus.ex_pc, bus.ex_jump_type, bus.ex_mem_read);
    else pass_cnt++;
    total_cnt++;
    if (bus.stall_out !== 1'b0) $display("FAIL reset_stall got %0b want 0", bus.stall_out);
    else pass_cnt++;
    total_cnt++;
    if (bus.bubble_count !== 16'd0) $display("FAIL reset_bubble_count got %0d want 0", bus.bubble_count);
    else pass_cnt++;

    to_negedge();
    reset_n = 1'b1;
    clear_id();
    bus.id_valid = 1'b1;
    bus.id_alu_select = 4'b0101;
    bus.id_rd = 5'd3;
    after_posedge();
    total_cnt++;
    if (bus.ex_alu_select !== 4'b0101 || bus.ex_rd !== 5'd3 || bus.ex_valid !== 1'b1)
      $display("FAIL first_capture alu=%b rd=%0d valid=%0b want 0101/3/1",
               bus.ex_alu_select, bus.ex_rd, bus.ex_valid);
    else pass_cnt++;
  endtask

  task automatic test_load_use_rs();
    to_negedge();
    drive_load(5'd7);
    after_posedge();
    to_negedge();
    clear_id();
    bus.id_valid = 1'b1;
    bus.id_reg_write = 1'b1;
    bus.id_alu_select = 4'd2;
    bus.id_rs = 5'd7;
    bus.id_rt = 5'd9;
    bus.id_rd = 5'd8;
    bus.id_rs_data = 32'h1234;
    #1;
    total_cnt++;
    if (bus.stall_out !== 1'b1) $display("FAIL lu_rs_stall got %0b want 1", bus.stall_out);
    else pass_cnt++;
    after_posedge();
    exp_bubbles++;
    total_cnt++;
    if (bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd0 || bus.ex_mem_read !== 1'b0)
      $display("FAIL lu_rs_bubble valid=%0b rd=%0d mr=%0b want 0/0/0", bus.ex_valid, bus.ex_rd, bus.ex_mem_read);
    else pass_cnt++;
    total_cnt++;
    if (bus.bubble_count !== 16'(exp_bubbles))
      $display("FAIL lu_rs_count got %0d want %0d", bus.bubble_count, exp_bubbles);
    else pass_cnt++;
    total_cnt++;
    if (bus.stall_out !== 1'b0) $display("FAIL lu_rs_stall_release got %0b want 0", bus.stall_out);
    else pass_cnt++;
    after_posedge();
    total_cnt++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd8 || bus.ex_rs !== 5'd7 ||
        bus.ex_rs_data !== 32'h1234 || bus.ex_alu_select !== 4'd2)
      $display("FAIL lu_rs_dependent valid=%0b rd=%0d rs=%0d rs_data=%0h alu=%0d want 1/8/7/1234/2",
               bus.ex_valid, bus.ex_rd, bus.ex_rs, bus.ex_rs_data, bus.ex_alu_select);
    else pass_cnt++;
  endtask

  task automatic test_rt_imm();
    to_negedge();
    drive_load(5'd4);
    after_posedge();
    to_negedge();
    clear_id();
    bus.id_valid = 1'b1;
    bus.id_rs = 5'd1;
    bus.id_rt = 5'd4;
    bus.id_alu_second_input_is_immidiate = 1'b1;
    bus.id_reg_write = 1'b1;
    #1;
    total_cnt++;
    if (bus.stall_out !== 1'b0) $display("FAIL rt_imm_no_stall got %0b want 0", bus.stall_out);
    else pass_cnt++;
    bus.id_reg_write = 1'b0;
    bus.id_mem_write = 1'b1;
    #1;
    total_cnt++;
    if (bus.stall_out !== 1'b1) $display("FAIL rt_store_stall got %0b want 1", bus.stall_out);
    else pass_cnt++;
    bus.id_mem_write = 1'b0;
    bus.id_alu_second_input_is_immidiate = 1'b0;
    #1;
    total_cnt++;
    if (bus.stall_out !== 1'b1) $display("FAIL rt_rtype_stall got %0b want 1", bus.stall_out);
    else pass_cnt++;
    after_posedge();
    exp_bubbles++;
    total_cnt++;
    if (bus.ex_valid !== 1'b0 || bus.bubble_count !== 16'(exp_bubbles))
      $display("FAIL rt_bubble valid=%0b count=%0d want 0/%0d", bus.ex_valid, bus.bubble_count, exp_bubbles);
    else pass_cnt++;
  endtask

  task automatic test_reg_zero();
    to_negedge();
    drive_load(5'd0);
    after_posedge();
    to_negedge();
    clear_id();
    bus.id_valid = 1'b1;
    bus.id_rs = 5'd0;
    bus.id_rt = 5'd0;
    bus.id_rd = 5'd11;
    #1;
    total_cnt++;
    if (bus.stall_out !== 1'b0) $display("FAIL r0_stall got %0b want 0", bus.stall_out);
    else pass_cnt++;
    after_posedge();
    total_cnt++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd11 || bus.bubble_count !== 16'(exp_bubbles))
      $display("FAIL r0_pass valid=%0b rd=%0d count=%0d want 1/11/%0d",
               bus.ex_valid, bus.ex_rd, bus.bubble_count, exp_bubbles);
    else pass_cnt++;
  endtask

  task automatic test_flush_stall();
    to_negedge();
    drive_load(5'd5);
    after_posedge();
    to_negedge();
    clear_id();
    bus.id_valid = 1'b1;
    bus.id_rs = 5'd5;
    bus.id_rd = 5'd6;
    bus.id_jump_type = 3'b001;
    bus.id_pc = 32'h40;
    bus.ex_branch_taken = 1'b1;
    #1;
    total_cnt++;
    if (bus.stall_out !== 1'b0) $display("FAIL flush_stall_suppressed got %0b want 0", bus.stall_out);
    else pass_cnt++;
    after_posedge();
    exp_bubbles++;
    total_cnt++;
    if (bus.ex_valid !== 1'b0 || bus.ex_jump_type !== 3'd0 || bus.bubble_count !== 16'(exp_bubbles))
      $display("FAIL flush_bubble valid=%0b jt=%0d count=%0d want 0/0/%0d",
               bus.ex_valid, bus.ex_jump_type, bus.bubble_count, exp_bubbles);
    else pass_cnt++;
    to_negedge();
    bus.ex_branch_taken = 1'b0;
    after_posedge();
    total_cnt++;
    if (bus.ex_valid !== 1'b1 || bus.ex_jump_type !== 3'b001 || bus.ex_rd !== 5'd6 ||
        bus.ex_pc !== 32'h40 || bus.bubble_count !== 16'(exp_bubbles))
      $display("FAIL flush_next_pass valid=%0b jt=%0d rd=%0d pc=%0h count=%0d want 1/1/6/40/%0d",
               bus.ex_valid, bus.ex_jump_type, bus.ex_rd, bus.ex_pc, bus.bubble_count, exp_bubbles);
    else pass_cnt++;
  endtask

  task automatic test_invalid_passthrough();
    to_negedge();
    clear_id();
    bus.id_valid = 1'b0;
    bus.id_rd = 5'd9;
    bus.id_rs_data = 32'hABCD;
    bus.id_imm = 32'hFFFF_FFF0;
    after_posedge();
    total_cnt++;
    if (bus.ex_valid !== 1'b0 || bus.ex_rd !== 5'd9 || bus.ex_rs_data !== 32'hABCD ||
        bus.ex_imm !== 32'hFFFF_FFF0 || bus.bubble_count !== 16'(exp_bubbles))
      $display("FAIL invalid_pass valid=%0b rd=%0d rs_data=%0h imm=%0h count=%0d want 0/9/abcd/fffffff0/%0d",
               bus.ex_valid, bus.ex_rd, bus.ex_rs_data, bus.ex_imm, bus.bubble_count, exp_bubbles);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_stall();
    to_negedge();
    drive_load(5'd12);
    after_posedge();
    to_negedge();
    clear_id();
    bus.id_valid = 1'b1;
    bus.id_rs = 5'd12;
    #1;
    total_cnt++;
    if (bus.stall_out !== 1'b1) $display("FAIL mid_stall_setup got %0b want 1", bus.stall_out);
    else pass_cnt++;
    #1;
    reset_n = 1'b0;
    #1;
    exp_bubbles = 0;
    total_cnt++;
    if (bus.stall_out !== 1'b0 || bus.ex_valid !== 1'b0 || bus.ex_mem_read !== 1'b0 ||
        bus.ex_rd !== 5'd0 || bus.bubble_count !== 16'd0)
      $display("FAIL mid_stall_reset stall=%0b valid=%0b mr=%0b rd=%0d count=%0d want all 0",
               bus.stall_out, bus.ex_valid, bus.ex_mem_read, bus.ex_rd, bus.bubble_count);
    else pass_cnt++;
    to_negedge();
    reset_n = 1'b1;
    clear_id();
    after_posedge();
  endtask

  task automatic test_saturation();
    to_negedge();
    clear_id();
    bus.id_valid = 1'b1;
    bus.id_rd = 5'd2;
    bus.ex_branch_taken = 1'b1;
    for (int i = 0; i < 65534; i++) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.bubble_count !== 16'hFFFE) $display("FAIL sat_pre got %0h want fffe", bus.bubble_count);
    else pass_cnt++;
    after_posedge();
    total_cnt++;
    if (bus.bubble_count !== 16'hFFFF) $display("FAIL sat_reach got %0h want ffff", bus.bubble_count);
    else pass_cnt++;
    after_posedge();
    after_posedge();
    total_cnt++;
    if (bus.bubble_count !== 16'hFFFF || bus.ex_valid !== 1'b0)
      $display("FAIL sat_hold count=%0h valid=%0b want ffff/0", bus.bubble_count, bus.ex_valid);
    else pass_cnt++;
    to_negedge();
    bus.ex_branch_taken = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    reset_n = 1'b0;
    clear_id();
    test_reset();
    test_load_use_rs();
    test_rt_imm();
    test_reg_zero();
    test_flush_stall();
    test_invalid_passthrough();
    test_reset_mid_stall();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
